// File: rtl/serial_adder_n.sv
// Multi-cycle adder: WIDTH-bit x + y + c_in, BITS_PER_CYCLE bits per clock, start/busy/done handshake.
// Optional subtract mode (y inverted on accept) is compiled in with `define SERIAL_ADDER_SUB_EN.
module serial_adder_n #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int K  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [WIDTH-1:0]          x_reg;
    logic [WIDTH-1:0]          y_reg;
    logic [WIDTH-1:0]          y_load;
    logic                      carry;
    logic [CW-1:0]             cnt;
    logic [BITS_PER_CYCLE-1:0] chunk_sum;
    logic [BITS_PER_CYCLE:0]   chain;
    logic [WIDTH-1:0]          result_next;

    // Handshake: a request is taken on any rising edge with start=1 while busy=0
    // (IDLE or DONE); start during RUN is dropped, never queued.
    assign dbg_state = state;

`ifdef SERIAL_ADDER_SUB_EN
    assign y_load = sub ? ~y : y;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign y_load     = y;
`endif

    // Ripple chain of full-adder slices over the current low chunk.
    always_comb begin
        chain     = '0;
        chunk_sum = '0;
        chain[0]  = carry;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            chunk_sum[i] = x_reg[i] ^ y_reg[i] ^ chain[i];
            chain[i+1]   = (x_reg[i] & y_reg[i]) | (chain[i] & (x_reg[i] ^ y_reg[i]));
        end
    end

    // Completed chunks enter from the MSB side, so after K chunks the
    // concatenation below is the full result in natural bit order.
    generate
        if (K == 1) begin : g_single
            assign result_next = chunk_sum;
        end else begin : g_multi
            logic [WIDTH-BITS_PER_CYCLE-1:0] acc;
            assign result_next = {chunk_sum, acc};
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc <= '0;
                end else if (state == RUN) begin
                    acc <= result_next[WIDTH-1:BITS_PER_CYCLE];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        x_reg <= x;
                        y_reg <= y_load;
                        carry <= c_in;
                        cnt   <= CW'(K - 1);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    x_reg <= x_reg >> BITS_PER_CYCLE;
                    y_reg <= y_reg >> BITS_PER_CYCLE;
                    carry <= chain[BITS_PER_CYCLE];
                    if (cnt == '0) begin
                        // Last chunk: its top slice is the MSB, so chain[B-1] is the carry into it.
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= result_next;
                        c_out    <= chain[BITS_PER_CYCLE];
                        overflow <= chain[BITS_PER_CYCLE-1] ^ chain[BITS_PER_CYCLE];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, processing BITS_PER_CYCLE bits per clock through a chain of full-adder slices with a registered carry. It is the sequential successor to the team's single-bit full adder. It trades latency for area and exposes a start/busy/done handshake so a controller or bench can issue back-to-back additions.

## Interface
- WIDTH, 8, operand and sum width in bits; must be ≥1.
- BITS_PER_CYCLE, 1, bits added per clock; must divide WIDTH exactly.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; accepted only when busy=0.
- x  input  WIDTH  operand A; sampled on the accepting edge.
- y  input  WIDTH  operand B; sampled on the accepting edge.
- c_in  input  1  carry into bit 0; sampled on the accepting edge.
- sub  input  1  subtract-mode select; used only when SERIAL_ADDER_SUB_EN is defined.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when a result is written.
- sum  output  WIDTH  result; holds the last completed value.
- c_out  output  1  carry out of the MSB for the last result.
- overflow  output  1  signed overflow for the last result: carry into the MSB XOR c_out.

## Operation
- K = WIDTH/BITS_PER_CYCLE chunks per addition.
- FSM states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- IDLE or DONE with start=1 → RUN:
  - latch x and y into operand shift registers;
  - load the carry register with c_in;
  - load the chunk counter with K-1.
- IDLE or DONE with start=0 → IDLE. DONE always leaves after one cycle.
- Each RUN cycle:
  - add the low BITS_PER_CYCLE bits of the x/y registers plus the carry register;
  - shift the partial sum into an internal result register from the MSB side;
  - shift both operand registers right by BITS_PER_CYCLE;
  - update the carry register with the chunk carry-out.
- RUN with counter=0 (last chunk) → DONE:
  - copy the completed result to sum;
  - set c_out to the final carry;
  - set overflow from the carry into the MSB XOR the final carry.
- sum, c_out and overflow change only on the completing edge and are stable at all other times.
- start while busy=1 is ignored; it is not queued.
- Arithmetic: sum = (x + y + c_in) mod 2^WIDTH; c_out = bit WIDTH of the exact sum.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, overflow=0. The FSM goes to IDLE and the counter and carry register clear.
- rst has priority over start on the same edge.
- Reset in RUN aborts the operation; outputs take their reset values on that edge.
- Accepting edge T (start=1, busy=0): busy=1 from T.
- Chunks are processed on edges T+1 … T+K.
- At edge T+K: result outputs update, busy=0, done=1 for one cycle.
- Latency: K+1 edges from start to done. With WIDTH=8, BITS_PER_CYCLE=1 this is 9.
- Back-to-back operation: start held high during the DONE cycle is accepted. The next done arrives K+1 edges later, with no idle gap.
- WIDTH=BITS_PER_CYCLE gives K=1, so done follows start by 2 edges.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub=1 latches ~y instead of y, so the result is x + ~y + c_in;
  - x−y requires c_in=1, and c_out=1 means no borrow;
  - sub is sampled on the accepting edge only.
- SERIAL_ADDER_SUB_EN undefined:
  - the sub port exists but is ignored, and y is always latched unmodified;
  - no inversion logic is synthesised.

## Test plan
- Exhaustive slice check (WIDTH=1, BITS_PER_CYCLE=1): apply all 8 (x,y,c_in) combinations, 000 through 111. Required: sum/c_out equal the full-adder truth table (0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1) with done 2 edges after each start.
- WIDTH=8, BITS_PER_CYCLE=1 carry and overflow:
  - x=0xFF, y=0x01, c_in=0 → sum=0x00, c_out=1, overflow=0, done 9 edges after start;
  - x=0x7F, y=0x01 → sum=0x80, c_out=0, overflow=1.
- WIDTH=8, BITS_PER_CYCLE=4: x=0xA5, y=0x5B, c_in=1 → sum=0x01, c_out=1, with done 3 edges after start.
- Handshake:
  - start pulsed again mid-RUN → ignored, single done, result unchanged;
  - start held through DONE → second result (x=0x10, y=0x20 → 0x30) completes 9 edges later.
- Reset mid-RUN (edge T+4): busy=0, done=0, sum=0, c_out=0, overflow=0 on that edge; no done pulse follows.
- sub=1, x=0x05, y=0x07, c_in=1:
  - with SERIAL_ADDER_SUB_EN → sum=0xFE, c_out=0;
  - without it → sum=0x0D, c_out=0.
